// File: rtl/gate_pkg.sv
// gate_pkg: shared state encoding, bus width and default timing constants for the gate servo.
package gate_pkg;
   typedef enum logic [1:0] {
      CLOSED  = 2'd0,
      OPENING = 2'd1,
      OPEN    = 2'd2,
      CLOSING = 2'd3
   } gate_state_e;
   localparam int WIDTH_W          = 19;
   localparam int DEF_FRAME_TICKS  = 500000;
   localparam int DEF_CLOSED_WIDTH = 7000;
   localparam int DEF_OPEN_WIDTH   = 52500;
   localparam int DEF_STEP         = 2500;
   localparam int DEF_HOLD_FRAMES  = 150;
endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: frame counter with end-of-frame tick and registered PWM compare.
// Ports: clk_in/rst clock and sync reset; width pulse width in cycles;
//        pwm_out registered (count < width); frame_tick high on the last cycle of a frame.
module servo_frame_timer
   import gate_pkg::*;
#(
   parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic [WIDTH_W-1:0] width,
   output logic               pwm_out,
   output logic               frame_tick
);
   localparam logic [WIDTH_W-1:0] LAST = WIDTH_W'(FRAME_TICKS - 1);
   logic [WIDTH_W-1:0] count;
   assign frame_tick = count == LAST;
   always_ff @(posedge clk_in) begin
      if (rst) begin
         count   <= '0;
         pwm_out <= 1'b0;
      end else begin
         count   <= frame_tick ? '0 : count + 1'b1;
         pwm_out <= count < width;
      end
   end
endmodule

// File: rtl/gate_servo_ctrl.sv
// gate_servo_ctrl: ramps the servo pulse width between closed and open once per frame.
// Ports: clk_in/rst clock and sync reset; open_req/obstruct synchronized levels;
//        pwm_out servo pulse; width_out active width; state_out FSM state; frame_tick frame end.
module gate_servo_ctrl
   import gate_pkg::*;
#(
   parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
   parameter int CLOSED_WIDTH = DEF_CLOSED_WIDTH,
   parameter int OPEN_WIDTH   = DEF_OPEN_WIDTH,
   parameter int STEP         = DEF_STEP,
   parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic               open_req,
   input  logic               obstruct,
   output logic               pwm_out,
   output logic [WIDTH_W-1:0] width_out,
   output logic [1:0]         state_out,
   output logic               frame_tick
);
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [WIDTH_W-1:0] CW = WIDTH_W'(CLOSED_WIDTH);
   localparam logic [WIDTH_W-1:0] OW = WIDTH_W'(OPEN_WIDTH);
   localparam logic [WIDTH_W-1:0] ST = WIDTH_W'(STEP);
   localparam logic [HOLD_W-1:0]  HF = HOLD_W'(HOLD_FRAMES);
   gate_state_e        state;
   logic [WIDTH_W-1:0] width_cur, up, dn;
   logic [HOLD_W-1:0]  hold;
   logic               reopen;
   // Bounds are tested before the add/subtract so the 19-bit width can never wrap.
   always_comb begin
      up     = (width_cur >= OW - ST) ? OW : width_cur + ST;
      dn     = (width_cur <= CW + ST) ? CW : width_cur - ST;
      reopen = open_req | obstruct;
   end
   servo_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_timer (
      .clk_in    (clk_in),
      .rst       (rst),
      .width     (width_cur),
      .pwm_out   (pwm_out),
      .frame_tick(frame_tick)
   );
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= CLOSED;
         width_cur <= CW;
         hold      <= '0;
      end else if (frame_tick) begin
         case (state)
            CLOSED: if (open_req) begin
               state     <= OPENING;
               width_cur <= up;
            end
            OPENING: begin
               width_cur <= up;
               if (up == OW) begin
                  state <= OPEN;
                  hold  <= HF;
               end
            end
            OPEN: if (reopen) hold <= HF;
            else begin
               hold <= hold - 1'b1;
               if (hold == HOLD_W'(1)) state <= CLOSING;
            end
            CLOSING: if (reopen) begin
               state     <= OPENING;
               width_cur <= up;
            end else begin
               width_cur <= dn;
               if (dn == CW) state <= CLOSED;
            end
            default: state <= CLOSED;
         endcase
      end
   end
   assign width_out = width_cur;
   assign state_out = state;
endmodule

// File: tb/tb_gate_servo_ctrl.sv
// tb_gate_servo_ctrl: directed and randomized checks of gate_servo_ctrl against a frame-level model.
module tb_gate_servo_ctrl;
   localparam int FT = 100, CWD = 10, OWD = 60, STP = 20, HFR = 3;
   logic        clk_in = 1'b0;
   logic        rst = 1'b1, open_req = 1'b0, obstruct = 1'b0;
   logic        pwm_out, frame_tick;
   logic [18:0] width_out;
   logic [1:0]  state_out;
   int total = 0, bad = 0;
   int m_cnt = 0, m_w = CWD, m_st = 0, m_hold = 0;
   bit m_valid = 1'b0;

   gate_servo_ctrl #(
      .FRAME_TICKS(FT), .CLOSED_WIDTH(CWD), .OPEN_WIDTH(OWD), .STEP(STP), .HOLD_FRAMES(HFR)
   ) dut (
      .clk_in(clk_in), .rst(rst), .open_req(open_req), .obstruct(obstruct),
      .pwm_out(pwm_out), .width_out(width_out), .state_out(state_out), .frame_tick(frame_tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: the position only moves at frame ends, by at most one step, within the travel limits.
   always @(posedge clk_in) begin
      if (rst) begin
         m_valid = 1'b1;
         m_cnt = 0; m_w = CWD; m_st = 0; m_hold = 0;
      end else if (m_valid) begin
         if (m_cnt == FT - 1) begin
            case (m_st)
               0: if (open_req) begin m_st = 1; m_w = (m_w + STP > OWD) ? OWD : m_w + STP; end
               1: begin
                  m_w = (m_w + STP > OWD) ? OWD : m_w + STP;
                  if (m_w == OWD) begin m_st = 2; m_hold = HFR; end
               end
               2: if (open_req || obstruct) m_hold = HFR;
                  else if (m_hold == 1) begin m_st = 3; m_hold = 0; end
                  else m_hold = m_hold - 1;
               default: if (open_req || obstruct) begin
                     m_st = 1; m_w = (m_w + STP > OWD) ? OWD : m_w + STP;
                  end else begin
                     m_w = (m_w - STP < CWD) ? CWD : m_w - STP;
                     if (m_w == CWD) m_st = 0;
                  end
            endcase
            m_cnt = 0;
         end else m_cnt = m_cnt + 1;
      end
   end

   // Every cycle: pulse is high on frame positions 1..width, tick on the last position.
   always @(negedge clk_in) begin
      if (m_valid) begin
         check("pwm_out", int'(pwm_out), int'(m_cnt >= 1 && m_cnt <= m_w));
         check("frame_tick", int'(frame_tick), int'(m_cnt == FT - 1));
         check("width_out", int'(width_out), m_w);
         check("state_out", int'(state_out), m_st);
      end
   end

   task automatic next_frame();
      int n = 0;
      @(negedge clk_in);
      while (!frame_tick && n < 3 * FT) begin @(negedge clk_in); n++; end
      if (n >= 3 * FT) begin
         total++; bad++;
         $display("FAIL tick_timeout: no frame_tick within %0d cycles", n);
      end
      @(negedge clk_in);
   endtask

   task automatic frame_exp(input string tag, input int w, input int s);
      next_frame();
      check({tag, "_width"}, int'(width_out), w);
      check({tag, "_state"}, int'(state_out), s);
   endtask

   initial begin
      int highs, n;
      repeat (3) begin
         @(negedge clk_in);
         check("rst_pwm", int'(pwm_out), 0);
         check("rst_width", int'(width_out), 10);
         check("rst_state", int'(state_out), 0);
      end
      rst = 1'b0;
      next_frame();
      highs = 0;
      repeat (FT) begin highs += int'(pwm_out); @(negedge clk_in); end
      check("closed_high_cycles", highs, 10);
      open_req = 1'b1;
      frame_exp("ramp1", 30, 1); frame_exp("ramp2", 50, 1); frame_exp("ramp3", 60, 2);
      open_req = 1'b0;
      frame_exp("hold1", 60, 2); frame_exp("hold2", 60, 2); frame_exp("hold3", 60, 3);
      frame_exp("close1", 40, 3); frame_exp("close2", 20, 3); frame_exp("close3", 10, 0);
      open_req = 1'b1;
      frame_exp("reramp1", 30, 1); frame_exp("reramp2", 50, 1); frame_exp("reramp3", 60, 2);
      open_req = 1'b0;
      frame_exp("rehold1", 60, 2); frame_exp("rehold2", 60, 2); frame_exp("rehold3", 60, 3);
      frame_exp("reclose", 40, 3);
      obstruct = 1'b1;
      frame_exp("obst1", 60, 1); frame_exp("obst2", 60, 2);
      obstruct = 1'b0;
      repeat (6) next_frame();
      check("closed_again_state", int'(state_out), 0);
      repeat (40) @(negedge clk_in);
      open_req = 1'b1;
      repeat (5) @(negedge clk_in);
      open_req = 1'b0;
      frame_exp("glitch", 10, 0);
      open_req = 1'b1;
      frame_exp("mid1", 30, 1); frame_exp("mid2", 50, 1);
      repeat (17) @(negedge clk_in);
      rst = 1'b1;
      @(negedge clk_in);
      check("midrst_width", int'(width_out), 10);
      check("midrst_state", int'(state_out), 0);
      rst = 1'b0;
      n = 0;
      while (!frame_tick && n < 2 * FT) begin @(negedge clk_in); n++; end
      check("midrst_restart", n, FT - 1);
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk_in);
         if ($urandom_range(399) == 0) open_req = ~open_req;
         if ($urandom_range(499) == 0) obstruct = ~obstruct;
         rst = ($urandom_range(2999) == 0);
      end
      rst = 1'b0;
      @(negedge clk_in);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
